// File: rtl/bp_be_late_wb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bp_be_late_wb_arb_pkg
//  Purpose  : Shared types and constants for the backend late-writeback
//             arbiter: the writeback packet layout, the starvation counter
//             width and the source identifier used for round-robin state.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package bp_be_late_wb_arb_pkg;

    localparam int reg_addr_width_gp       = 5;
    localparam int dpath_width_gp          = 64;
    localparam int late_wb_starve_width_gp = 4;

    typedef struct packed {
        logic                         ird_w_v;
        logic                         frd_w_v;
        logic                         late;
        logic [reg_addr_width_gp-1:0] rd_addr;
        logic [dpath_width_gp-1:0]    rd_data;
        logic                         fflags_w_v;
        logic [4:0]                   fflags;
    } bp_be_wb_pkt_s;

    localparam int wb_pkt_width_lp = $bits(bp_be_wb_pkt_s);

    typedef enum logic [0:0] {
        e_src0 = 1'b0,
        e_src1 = 1'b1
    } late_wb_src_e;

    // A captured late packet always targets exactly one register file (the
    // one this instance serves), whatever the producer put in the flags.
    function automatic bp_be_wb_pkt_s late_wb_normalize(input bp_be_wb_pkt_s pkt,
                                                        input logic          float_en);
        bp_be_wb_pkt_s r;
        r         = pkt;
        r.late    = 1'b1;
        r.ird_w_v = ~float_en;
        r.frd_w_v = float_en;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_be_late_wb_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : bp_be_late_wb_arb_if
//  Purpose  : Bundles the two producer handshakes, the regfile late write
//             port and the scoreboard clear / drain status of the arbiter.
//  Ports    : master - producers + regfile side (drives pkt/v/port_free)
//             slave  - arbiter side (drives yumi, wb packet, clear, busy)
//  Revision : 1.0  initial release
// ============================================================================
interface bp_be_late_wb_arb_if;
    import bp_be_late_wb_arb_pkg::*;

    bp_be_wb_pkt_s                src0_pkt_i;
    logic                         src0_v_i;
    logic                         src0_yumi_o;
    bp_be_wb_pkt_s                src1_pkt_i;
    logic                         src1_v_i;
    logic                         src1_yumi_o;
    logic                         port_free_i;
    bp_be_wb_pkt_s                wb_pkt_o;
    logic                         wb_v_o;
    logic                         clr_v_o;
    logic [reg_addr_width_gp-1:0] clr_addr_o;
    logic                         busy_o;

    modport master (
        output src0_pkt_i, src0_v_i, src1_pkt_i, src1_v_i, port_free_i,
        input  src0_yumi_o, src1_yumi_o, wb_pkt_o, wb_v_o, clr_v_o, clr_addr_o, busy_o
    );

    modport slave (
        input  src0_pkt_i, src0_v_i, src1_pkt_i, src1_v_i, port_free_i,
        output src0_yumi_o, src1_yumi_o, wb_pkt_o, wb_v_o, clr_v_o, clr_addr_o, busy_o
    );

endinterface
`default_nettype wire

// File: rtl/bp_be_late_wb_rr_grant.sv
`default_nettype none
// ============================================================================
//  Module   : bp_be_late_wb_rr_grant
//  Purpose  : Two-input round-robin grant with a starvation override. The
//             grant is combinational; the last winner and per-source
//             lost-arbitration counters are registered.
//  Ports    : clk_i, reset_i (async, active high)
//             v_i[1:0]     - source valids
//             en_i         - arbitration enabled (downstream can accept)
//             grant_o[1:0] - one-hot grant, zero when en_i is low
//  Revision : 1.0  initial release
// ============================================================================
module bp_be_late_wb_rr_grant
    import bp_be_late_wb_arb_pkg::*;
#(
    parameter int starve_limit_p = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] v_i,
    input  logic       en_i,
    output logic [1:0] grant_o
);

    localparam int W = late_wb_starve_width_gp;
    localparam logic [W-1:0] limit_lp = W'(starve_limit_p);

    logic [1:0][W-1:0] starve_q, starve_d;
    late_wb_src_e      rr_last_q, rr_last_d;

    // Forced priority is evaluated for src0 before src1 so that two starving
    // sources still resolve deterministically.
    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            case (v_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11: begin
                    if (starve_q[0] >= limit_lp)      grant_o = 2'b01;
                    else if (starve_q[1] >= limit_lp) grant_o = 2'b10;
                    else if (rr_last_q == e_src1)     grant_o = 2'b01;
                    else                              grant_o = 2'b10;
                end
                default: grant_o = 2'b00;
            endcase
        end
    end

    // A waiting source that is not served this cycle (lost the tie or the
    // output stage is stalled) accumulates; being served or idle clears it.
    always_comb begin
        starve_d = starve_q;
        for (int i = 0; i < 2; i++) begin
            if (!v_i[i] || grant_o[i])
                starve_d[i] = '0;
            else if (!(&starve_q[i]))
                starve_d[i] = starve_q[i] + 1'b1;
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (grant_o[0])      rr_last_d = e_src0;
        else if (grant_o[1]) rr_last_d = e_src1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            starve_q  <= '0;
            rr_last_q <= e_src1;
        end else begin
            starve_q  <= starve_d;
            rr_last_q <= rr_last_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bp_be_late_wb_arb.sv
`default_nettype none
// ============================================================================
//  Module   : bp_be_late_wb_arb
//  Purpose  : Arbitrates late (post-commit) writebacks from the memory pipe
//             (src0) and the long-latency pipe (src1) into one register-file
//             late write port, through a single-entry output stage, and
//             raises the scoreboard clear for the written rd.
//  Ports    : clk_i, reset_i (async, active high)
//             bus_if.slave - src0/src1 pkt, v, yumi; port_free; wb_pkt, wb_v;
//                            clr_v, clr_addr; busy
//  Params   : starve_limit_p (1..15), float_p (0 = int file, 1 = FP file)
//  Revision : 1.0  initial release
// ============================================================================
module bp_be_late_wb_arb
    import bp_be_late_wb_arb_pkg::*;
#(
    parameter int starve_limit_p = 4,
    parameter bit float_p        = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    bp_be_late_wb_arb_if.slave bus_if
);

    bp_be_wb_pkt_s pkt_q, pkt_d;
    logic          v_q, v_d;
    logic          deq, load_en;
    logic [1:0]    grant;

    // The stage refills in the same cycle it drains: one write per cycle.
    assign deq     = v_q & bus_if.port_free_i;
    assign load_en = ~v_q | deq;

    bp_be_late_wb_rr_grant #(
        .starve_limit_p (starve_limit_p)
    ) u_grant (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     ({bus_if.src1_v_i, bus_if.src0_v_i}),
        .en_i    (load_en),
        .grant_o (grant)
    );

    // Payload only changes on an actual capture; with nothing granted the
    // stage just goes empty and keeps the stale payload.
    always_comb begin
        pkt_d = pkt_q;
        v_d   = v_q;
        if (load_en) begin
            v_d = |grant;
            if (grant[0])
                pkt_d = late_wb_normalize(bus_if.src0_pkt_i, float_p);
            else if (grant[1])
                pkt_d = late_wb_normalize(bus_if.src1_pkt_i, float_p);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_q   <= 1'b0;
            pkt_q <= '0;
        end else begin
            v_q   <= v_d;
            pkt_q <= pkt_d;
        end
    end

    // Combinational outputs are masked by reset so nothing is consumed or
    // reported busy while the block is held in reset.
    assign bus_if.src0_yumi_o = grant[0] & ~reset_i;
    assign bus_if.src1_yumi_o = grant[1] & ~reset_i;
    assign bus_if.wb_pkt_o    = pkt_q;
    assign bus_if.wb_v_o      = v_q;
    assign bus_if.clr_v_o     = deq;
    assign bus_if.clr_addr_o  = pkt_q.rd_addr;
    assign bus_if.busy_o      = (v_q | bus_if.src0_v_i | bus_if.src1_v_i) & ~reset_i;

endmodule
`default_nettype wire

// File: tb/tb_bp_be_late_wb_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_be_late_wb_arb
//  Purpose  : Self-checking bench for bp_be_late_wb_arb. Runs an integer
//             instance (starve limit 2) and an FP instance (starve limit 4)
//             side by side with random producers and port availability,
//             against a behavioural model of the arbitration rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bp_be_late_wb_arb;
    import bp_be_late_wb_arb_pkg::*;

    logic clk_i;
    logic reset_i;

    bp_be_late_wb_arb_if bus_int ();
    bp_be_late_wb_arb_if bus_fp ();

    bp_be_late_wb_arb #(.starve_limit_p(2), .float_p(1'b0)) u_dut_int (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus_if  (bus_int)
    );

    bp_be_late_wb_arb #(.starve_limit_p(4), .float_p(1'b1)) u_dut_fp (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus_if  (bus_fp)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks;
    int passed;

    // Model state, index k: 0 = integer instance, 1 = FP instance
    bit            m_v    [2];
    bp_be_wb_pkt_s m_pkt  [2];
    int            m_last [2];     // index of last winner
    int            m_s    [2][2];  // consecutive cycles a source waited unserved
    // Producer state: pending packet per instance/source
    bit            p_v    [2][2];
    bp_be_wb_pkt_s p_pkt  [2][2];
    bit            g      [2][2];  // expected grants this cycle
    bit            free_r;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic string nm(input string s, input int k);
        return $sformatf("%s_%s", s, (k == 0) ? "int" : "fp");
    endfunction

    function automatic int lim_of(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic bp_be_wb_pkt_s rand_pkt();
        bp_be_wb_pkt_s p;
        p.ird_w_v    = 1'($urandom);
        p.frd_w_v    = 1'($urandom);
        p.late       = 1'($urandom);
        p.rd_addr    = 5'($urandom);
        p.rd_data    = {$urandom, $urandom};
        p.fflags_w_v = 1'($urandom);
        p.fflags     = 5'($urandom);
        return p;
    endfunction

    function automatic bp_be_wb_pkt_s tb_norm(input bp_be_wb_pkt_s p, input int k);
        bp_be_wb_pkt_s r;
        r         = p;
        r.late    = 1'b1;
        r.ird_w_v = (k == 0);
        r.frd_w_v = (k == 1);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_v[k]    = 1'b0;
            m_last[k] = 1;
            m_s[k][0] = 0;
            m_s[k][1] = 0;
        end
    endtask

    task automatic drive();
        bus_int.src0_v_i    = p_v[0][0];
        bus_int.src0_pkt_i  = p_pkt[0][0];
        bus_int.src1_v_i    = p_v[0][1];
        bus_int.src1_pkt_i  = p_pkt[0][1];
        bus_int.port_free_i = free_r;
        bus_fp.src0_v_i     = p_v[1][0];
        bus_fp.src0_pkt_i   = p_pkt[1][0];
        bus_fp.src1_v_i     = p_v[1][1];
        bus_fp.src1_pkt_i   = p_pkt[1][1];
        bus_fp.port_free_i  = free_r;
    endtask

    task automatic gen(input int new_pct);
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < 2; s++)
                if (!p_v[k][s] && ($urandom_range(0, 99) < new_pct)) begin
                    p_v[k][s]   = 1'b1;
                    p_pkt[k][s] = rand_pkt();
                end
    endtask

    // Compare one instance against the model, then advance the model by one cycle.
    task automatic eval_inst(input int k, input logic y0, input logic y1, input logic wv,
                             input logic cv, input logic [4:0] ca, input bp_be_wb_pkt_s wp,
                             input logic bz);
        bit deq, load, v0, v1;
        int lim;
        v0   = p_v[k][0];
        v1   = p_v[k][1];
        lim  = lim_of(k);
        deq  = m_v[k] && free_r;
        load = !m_v[k] || deq;
        g[k][0] = 1'b0;
        g[k][1] = 1'b0;
        if (load) begin
            if (v0 && v1) begin
                if (m_s[k][0] >= lim)      g[k][0] = 1'b1;
                else if (m_s[k][1] >= lim) g[k][1] = 1'b1;
                else if (m_last[k] == 0)   g[k][1] = 1'b1;
                else                       g[k][0] = 1'b1;
            end else if (v0) g[k][0] = 1'b1;
            else if (v1)     g[k][1] = 1'b1;
        end
        check(nm("yumi0", k), y0, g[k][0]);
        check(nm("yumi1", k), y1, g[k][1]);
        check(nm("wb_v", k), wv, m_v[k]);
        check(nm("clr_v", k), cv, deq);
        check(nm("busy", k), bz, m_v[k] || v0 || v1);
        if (m_v[k]) begin
            check(nm("clr_addr", k), ca, m_pkt[k].rd_addr);
            check(nm("wb_pkt", k), wp, m_pkt[k]);
        end
        for (int s = 0; s < 2; s++) begin
            if (!p_v[k][s] || g[k][s]) m_s[k][s] = 0;
            else if (m_s[k][s] < 15)   m_s[k][s] = m_s[k][s] + 1;
        end
        if (load) begin
            m_v[k] = g[k][0] || g[k][1];
            if (g[k][0]) begin
                m_pkt[k]  = tb_norm(p_pkt[k][0], k);
                m_last[k] = 0;
            end else if (g[k][1]) begin
                m_pkt[k]  = tb_norm(p_pkt[k][1], k);
                m_last[k] = 1;
            end
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic run_cycle(input int free_pct);
        free_r = ($urandom_range(0, 99) < free_pct);
        drive();
        @(negedge clk_i);
        eval_inst(0, bus_int.src0_yumi_o, bus_int.src1_yumi_o, bus_int.wb_v_o, bus_int.clr_v_o,
                  bus_int.clr_addr_o, bus_int.wb_pkt_o, bus_int.busy_o);
        eval_inst(1, bus_fp.src0_yumi_o, bus_fp.src1_yumi_o, bus_fp.wb_v_o, bus_fp.clr_v_o,
                  bus_fp.clr_addr_o, bus_fp.wb_pkt_o, bus_fp.busy_o);
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < 2; s++)
                if (g[k][s]) p_v[k][s] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wb_v_int"},  bus_int.wb_v_o,      1'b0);
        check({tag, "_clr_v_int"}, bus_int.clr_v_o,     1'b0);
        check({tag, "_yumi_int"},  {bus_int.src1_yumi_o, bus_int.src0_yumi_o}, 2'b00);
        check({tag, "_busy_int"},  bus_int.busy_o,      1'b0);
        check({tag, "_wb_v_fp"},   bus_fp.wb_v_o,       1'b0);
        check({tag, "_clr_v_fp"},  bus_fp.clr_v_o,      1'b0);
        check({tag, "_yumi_fp"},   {bus_fp.src1_yumi_o, bus_fp.src0_yumi_o}, 2'b00);
        check({tag, "_busy_fp"},   bus_fp.busy_o,       1'b0);
    endtask

    initial begin
        bp_be_wb_pkt_s pk;
        checks  = 0;
        passed  = 0;
        reset_i = 1'b1;
        free_r  = 1'b1;
        model_reset();

        // Sources valid while in reset: nothing may be consumed or flagged.
        gen(100);
        drive();
        #3;
        check_reset_outputs("rst");
        check("rst_pkt_int", bus_int.wb_pkt_o, '0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        // Lone src0 packet rd=5: captured next edge, written and cleared.
        for (int k = 0; k < 2; k++) begin
            p_v[k][0] = 1'b0;
            p_v[k][1] = 1'b0;
        end
        pk          = rand_pkt();
        pk.rd_addr  = 5'd5;
        p_v[0][0]   = 1'b1;
        p_pkt[0][0] = pk;
        run_cycle(100);
        check("rd5_wb_v", bus_int.wb_v_o, 1'b1);
        check("rd5_clr_addr", bus_int.clr_addr_o, 5'd5);
        run_cycle(100);
        run_cycle(100);

        // Random phases: varying arrival density and port availability.
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 400; i++) begin
                gen((ph % 2 == 1) ? 100 : 50);
                run_cycle((ph % 3 == 0) ? 100 : ((ph % 3 == 1) ? 50 : 15));
            end
        end

        // Fill both stages with the port blocked, then reset asynchronously.
        for (int i = 0; i < 4; i++) begin
            gen(100);
            run_cycle(0);
        end
        free_r = 1'b1;
        drive();
        #1;
        check("pre_rst_wb_v_int",  bus_int.wb_v_o,  m_v[0]);
        check("pre_rst_clr_v_int", bus_int.clr_v_o, m_v[0]);
        check("pre_rst_wb_v_fp",   bus_fp.wb_v_o,   m_v[1]);
        check("pre_rst_clr_v_fp",  bus_fp.clr_v_o,  m_v[1]);
        #1;
        reset_i = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk_i);
        #1;
        gen(100);
        drive();
        #1;
        reset_i = 1'b0;
        #1;
        check("tie_after_rst_int", bus_int.src0_yumi_o, 1'b1);
        check("tie_after_rst_fp",  bus_fp.src0_yumi_o,  1'b1);
        for (int i = 0; i < 200; i++) begin
            gen(80);
            run_cycle(60);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_be_late_wb_arb.md
Name: bp_be_late_wb_arb

Overview:
- Arbitrates late (post-commit) writeback packets from two producers into one register-file late write port.
- Producer 0 is the memory pipe late-writeback output (D$ miss fills of loads).
- Producer 1 is the long-latency pipe (int/FP divide, sqrt).
- Instantiated once for the integer file and once for the FP file. Registers the winning packet for one cycle and drives the scoreboard-clear pulse for its rd.

Parameters:
- bp_params_p, e_bp_default_cfg, processor configuration; supplies vaddr_width_p for wb packet width.
- starve_limit_p, 4, consecutive lost arbitrations after which a waiting source gets forced priority; legal range 1..15.
- float_p, 0, 0 = integer instance (tests ird_w_v), 1 = FP instance (tests frd_w_v).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- src0_pkt_i  in  wb_pkt_width_lp  memory-pipe late wb packet (bp_be_wb_pkt_s)
- src0_v_i  in  1  src0 valid; held until yumi
- src0_yumi_o  out  1  src0 consumed this cycle
- src1_pkt_i  in  wb_pkt_width_lp  long-latency pipe wb packet
- src1_v_i  in  1  src1 valid; held until yumi
- src1_yumi_o  out  1  src1 consumed this cycle
- port_free_i  in  1  regfile late write port unused by in-order writeback this cycle
- wb_pkt_o  out  wb_pkt_width_lp  packet to regfile
- wb_v_o  out  1  wb_pkt_o valid; a write happens when wb_v_o & port_free_i
- clr_v_o  out  1  scoreboard clear pulse, equal to wb_v_o & port_free_i
- clr_addr_o  out  reg_addr_width_gp  rd to clear, equal to wb_pkt_o.rd_addr
- busy_o  out  1  output stage full or any source valid; used by the fence/interrupt drain

Behaviour:
- Reset (asynchronous): output stage valid = 0, rr_last = 1 (src0 wins the first tie), starve counters = 0. All outputs are 0 during reset.
- Output stage:
  - One register holding pkt and valid.
  - deq = wb_v_o & port_free_i.
  - load_en = ~valid | deq, so the stage sustains one write per cycle.
- Grant, combinational, only when load_en:
  - only src0 valid -> src0; only src1 valid -> src1.
  - both valid:
    - if starve0 >= starve_limit_p -> src0;
    - else if starve1 >= starve_limit_p -> src1;
    - else the source != rr_last.
    - Forced priority is checked src0 first.
- srcN_yumi_o = load_en & grantN. At most one yumi per cycle. Yumi never asserts without srcN_v_i.
- Latency: a packet presented with an empty stage is captured at the next edge. wb_v_o is high the cycle after yumi, and the regfile write occurs on the first cycle port_free_i = 1.
- On grant:
  - rr_last <= winner.
  - Winner's starve counter <= 0.
  - Loser's counter (if it was valid) increments, saturating at 15.
- A source that is not valid has its counter cleared.
- Packet normalisation on capture:
  - late = 1.
  - ird_w_v = ~float_p and frd_w_v = float_p, forced regardless of input.
  - All other fields are passed unchanged.
- Stall: if wb_v_o & ~port_free_i, the stage holds pkt unchanged, no yumi is issued, and starve counters of waiting sources increment.
- Same rd from both sources: this is not a hazard here; the scoreboard prevents it. Writes retire in grant order.
- Reset mid-operation: a held packet is discarded. Producers own re-issue, and the pipeline is flushed anyway.
- No flush input: late writebacks are architecturally committed and are never killed.

Decomposition:
- bp_be_pkg: bp_be_wb_pkt_s (existing) and a new localparam late_wb_starve_width_gp = 4.
- One natural sub-module: bp_be_late_wb_rr_grant, a 2-input round-robin grant with starvation override (combinational grant, sequential rr_last and counters).
- The output stage is a bsg_dff_reset_en-style register with async reset, implemented inline.

Test Plan:
- Single src0 pkt rd=5 with port_free_i=1 -> src0_yumi_o at cycle 0; wb_v_o, clr_v_o, clr_addr_o=5 at cycle 1; busy_o low at cycle 2.
- Both valid continuously (rd 3 and 7), port_free_i=1 -> grants alternate src0,src1,src0…; one write per cycle, no bubble.
- port_free_i=0 for 6 cycles with a packet held -> wb_pkt_o stable, no yumi, clr_v_o=0; on release, the write occurs and the next grant loads in the same cycle.
- starve_limit_p=2: rr_last arranged so src1 loses twice consecutively -> third arbitration grants src1 even if round-robin points to src0.
- float_p=1 instance, input packet with ird_w_v=1, frd_w_v=0, late=0 -> output frd_w_v=1, ird_w_v=0, late=1.
- reset_i asserted asynchronously mid-cycle while wb_v_o=1 -> wb_v_o and clr_v_o drop immediately without a clock edge; after release, the first tie grants src0.
